// File: rtl/al_ram_init_ctrl.sv
// -----------------------------------------------------------------------------
// al_ram_init_ctrl
//
// Initialization and write-port controller for the partitioned active-list
// data RAM. It sits between the dispatch write lanes and the RAM.
//   - After reset, and whenever a partition powers up, it walks the affected
//     entries and clears them through write lane 0. Dispatch writes are
//     blocked for the whole clear.
//   - Once every active partition is clean, ready_o is raised. Dispatch writes
//     then pass straight through, gated per lane by the state of the
//     addressed partition.
//
// Configuration macro: AL_RAM_INIT_SEQ_EN
//   defined   - each cleared entry is written with its own index
//               (ptr zero-extended or truncated to WIDTH)
//   undefined - cleared entries are written with zero
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous reset, active low
//   partActive_i  partition power/enable mask
//   we_i          dispatch write enables, one per lane
//   addrWr_i      dispatch write addresses, lane i at [i*INDEX +: INDEX]
//   dataWr_i      dispatch write data, lane i at [i*WIDTH +: WIDTH]
//   we_o          write enables to the RAM
//   addrWr_o      write addresses to the RAM
//   dataWr_o      write data to the RAM
//   ready_o       RAM clean and accepting dispatch writes
//   errDrop_o     sticky flag: a dispatch write was dropped
// -----------------------------------------------------------------------------
module al_ram_init_ctrl #(
  parameter int DEPTH         = 16,
  parameter int INDEX         = 4,
  parameter int WIDTH         = 8,
  parameter int NUM_PARTS     = 4,
  parameter int NUM_PARTS_LOG = 2,
  parameter int WR_PORTS      = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_PARTS-1:0]      partActive_i,
  input  logic [WR_PORTS-1:0]       we_i,
  input  logic [WR_PORTS*INDEX-1:0] addrWr_i,
  input  logic [WR_PORTS*WIDTH-1:0] dataWr_i,
  output logic [WR_PORTS-1:0]       we_o,
  output logic [WR_PORTS*INDEX-1:0] addrWr_o,
  output logic [WR_PORTS*WIDTH-1:0] dataWr_o,
  output logic                      ready_o,
  output logic                      errDrop_o
);

  localparam int PART_SIZE = DEPTH / NUM_PARTS;
  localparam int OFFW      = INDEX - NUM_PARTS_LOG;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t               state_reg, state_next;
  logic [INDEX-1:0]     ptr_reg, ptr_next;
  logic [NUM_PARTS-1:0] pending_reg, pending_next;
  logic [NUM_PARTS-1:0] clean_reg, clean_next;
  logic [NUM_PARTS-1:0] prev_active_reg;
  logic                 err_drop_reg;

  logic [NUM_PARTS_LOG-1:0] cur_part;
  logic [NUM_PARTS_LOG-1:0] next_part;
  logic [OFFW-1:0]          cur_offset;
  logic                     last_entry;
  logic                     clear_wr;
  logic [NUM_PARTS-1:0]     rise;
  logic [WIDTH-1:0]         init_value;
  logic [WR_PORTS-1:0]      lane_pass;
  logic                     drop;

  // The scan pointer's upper bits name the partition being cleared.
  assign cur_part   = ptr_reg[INDEX-1 -: NUM_PARTS_LOG];
  assign next_part  = cur_part + NUM_PARTS_LOG'(1);
  assign cur_offset = ptr_reg[OFFW-1:0];
  assign last_entry = (cur_offset == OFFW'(PART_SIZE - 1));
  assign rise       = partActive_i & ~prev_active_reg;

  // A clear write happens only for a partition that is both pending and
  // powered; anything else costs a single skip cycle.
  assign clear_wr = (state_reg == CLEAR) && pending_reg[cur_part] && partActive_i[cur_part];

`ifdef AL_RAM_INIT_SEQ_EN
  assign init_value = WIDTH'(ptr_reg);
`else
  assign init_value = '0;
`endif

  always_comb begin
    ptr_next     = ptr_reg;
    pending_next = pending_reg;
    clean_next   = clean_reg;
    if (state_reg == CLEAR) begin
      if (clear_wr) begin
        // Natural INDEX-bit wrap takes the last entry back to 0.
        ptr_next = ptr_reg + INDEX'(1);
        if (last_entry) begin
          pending_next[cur_part] = 1'b0;
          clean_next[cur_part]   = 1'b1;
        end
      end else begin
        pending_next[cur_part] = 1'b0;
        ptr_next               = {next_part, {OFFW{1'b0}}};
      end
    end
    // Newly powered partitions join the scan without restarting the pointer;
    // the wrap-around picks up any partition already passed. Powered-down
    // partitions lose their clean status.
    pending_next = pending_next | rise;
    clean_next   = clean_next & ~rise & partActive_i;
    // In READY pending is empty, so this reduces to "any rise -> CLEAR".
    state_next   = (pending_next == '0) ? READY : CLEAR;
  end

  genvar gi;
  generate
    for (gi = 0; gi < WR_PORTS; gi++) begin : g_lane
      logic [NUM_PARTS_LOG-1:0] lane_part;
      assign lane_part     = addrWr_i[gi*INDEX + INDEX-1 -: NUM_PARTS_LOG];
      assign lane_pass[gi] = (state_reg == READY) && we_i[gi] &&
                             clean_reg[lane_part] && partActive_i[lane_part];
      if (gi == 0) begin : g_clear_lane
        // Lane 0 is borrowed by the clear sequencer outside READY.
        assign we_o[0]             = clear_wr | lane_pass[0];
        assign addrWr_o[INDEX-1:0] = (state_reg == CLEAR) ? ptr_reg : addrWr_i[INDEX-1:0];
        assign dataWr_o[WIDTH-1:0] = (state_reg == CLEAR) ? init_value : dataWr_i[WIDTH-1:0];
      end else begin : g_dispatch_lane
        assign we_o[gi]                    = lane_pass[gi];
        assign addrWr_o[gi*INDEX +: INDEX] = addrWr_i[gi*INDEX +: INDEX];
        assign dataWr_o[gi*WIDTH +: WIDTH] = dataWr_i[gi*WIDTH +: WIDTH];
      end
    end
  endgenerate

  // Any requested dispatch write that did not reach the RAM is a drop.
  assign drop = |(we_i & ~lane_pass);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= CLEAR;
      ptr_reg         <= '0;
      pending_reg     <= '1;
      clean_reg       <= '0;
      prev_active_reg <= '0;
      err_drop_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      ptr_reg         <= ptr_next;
      pending_reg     <= pending_next;
      clean_reg       <= clean_next;
      prev_active_reg <= partActive_i;
      err_drop_reg    <= err_drop_reg | drop;
    end
  end

  assign ready_o   = (state_reg == READY);
  assign errDrop_o = err_drop_reg;

endmodule

// File: tb/tb_al_ram_init_ctrl.sv
// -----------------------------------------------------------------------------
// tb_al_ram_init_ctrl
//
// Directed bench for al_ram_init_ctrl: table-driven READY-phase vectors plus
// hand-written sequences for clear timing, skips, activation while ready,
// activation mid-scan and asynchronous reset during a clear.
// -----------------------------------------------------------------------------
module tb_al_ram_init_ctrl;

  localparam int DEPTH         = 16;
  localparam int INDEX         = 4;
  localparam int WIDTH         = 8;
  localparam int NUM_PARTS     = 4;
  localparam int NUM_PARTS_LOG = 2;
  localparam int WR_PORTS      = 4;

`ifdef AL_RAM_INIT_SEQ_EN
  localparam logic [7:0] SEQ_MASK = 8'hFF;
`else
  localparam logic [7:0] SEQ_MASK = 8'h00;
`endif

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_PARTS-1:0]      partActive_i;
  logic [WR_PORTS-1:0]       we_i;
  logic [WR_PORTS*INDEX-1:0] addrWr_i;
  logic [WR_PORTS*WIDTH-1:0] dataWr_i;
  logic [WR_PORTS-1:0]       we_o;
  logic [WR_PORTS*INDEX-1:0] addrWr_o;
  logic [WR_PORTS*WIDTH-1:0] dataWr_o;
  logic                      ready_o;
  logic                      errDrop_o;

  int tests = 0;
  int fails = 0;

  al_ram_init_ctrl #(
    .DEPTH(DEPTH), .INDEX(INDEX), .WIDTH(WIDTH),
    .NUM_PARTS(NUM_PARTS), .NUM_PARTS_LOG(NUM_PARTS_LOG), .WR_PORTS(WR_PORTS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .partActive_i(partActive_i),
    .we_i(we_i),
    .addrWr_i(addrWr_i),
    .dataWr_i(dataWr_i),
    .we_o(we_o),
    .addrWr_o(addrWr_o),
    .dataWr_o(dataWr_o),
    .ready_o(ready_o),
    .errDrop_o(errDrop_o)
  );

  always #5 clk = ~clk;

  // RAM model fed by the controller's write ports.
  logic [7:0] ram [DEPTH];
  always @(posedge clk) begin
    for (int i = 0; i < WR_PORTS; i++)
      if (we_o[i]) ram[addrWr_o[i*INDEX +: INDEX]] <= dataWr_o[i*WIDTH +: WIDTH];
  end

  typedef struct {
    logic [3:0]  act;
    logic [3:0]  we;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  exp_we;
    logic        exp_err;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [7:0] init_val(int a);
    logic [7:0] v;
    v = 8'(a);
    return v & SEQ_MASK;
  endfunction

  task automatic check(string name, logic [31:0] actual, logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at the start of cycle 0 (reset just released).
  task automatic do_reset(logic [3:0] act);
    reset        = 1'b0;
    partActive_i = act;
    we_i         = '0;
    addrWr_i     = '0;
    dataWr_i     = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic expect_clear(string tag, int c, bit wr, int a);
    check($sformatf("%s c%0d we_o", tag, c), 32'(we_o), wr ? 32'd1 : 32'd0);
    if (wr) begin
      check($sformatf("%s c%0d addr0", tag, c), 32'(addrWr_o[3:0]), 32'(a));
      check($sformatf("%s c%0d data0", tag, c), 32'(dataWr_o[7:0]), 32'(init_val(a)));
    end
    check($sformatf("%s c%0d ready", tag, c), 32'(ready_o), 32'd0);
    $display("[TB] %s cycle %0d we_o=%b addr0=%0d ready=%b", tag, c, we_o, addrWr_o[3:0], ready_o);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Table: all rows run in READY after a full clear with all partitions on.
    // Row 4 powers partition 2 down: its lane is gated at once, and the drop
    // shows on errDrop_o from row 5.
    vecs[0] = '{4'b1111, 4'b0001, 16'h3210, 32'hDDCCBBAA, 4'b0001, 1'b0};
    vecs[1] = '{4'b1111, 4'b1111, 16'hF84C, 32'h12345678, 4'b1111, 1'b0};
    vecs[2] = '{4'b1111, 4'b1010, 16'h0000, 32'h00000000, 4'b1010, 1'b0};
    vecs[3] = '{4'b1111, 4'b0000, 16'h5A5A, 32'hFFFFFFFF, 4'b0000, 1'b0};
    vecs[4] = '{4'b1011, 4'b0110, 16'h0940, 32'hA5A5A5A5, 4'b0010, 1'b0};
    vecs[5] = '{4'b1011, 4'b1111, 16'h8A3F, 32'h0F1E2D3C, 4'b0011, 1'b1};

    // ---- A: all partitions active; dispatch writes during CLEAR ----------
    do_reset(4'b1111);
    for (int c = 0; c < 16; c++) begin
      if (c == 3) begin
        we_i = 4'b1111; addrWr_i = 16'hFFFF; dataWr_i = 32'hFFFFFFFF;
      end else begin
        we_i = '0;
      end
      #1;
      if (c == 0) check("A reset errDrop", 32'(errDrop_o), 32'd0);
      if (c == 4) check("A errDrop set", 32'(errDrop_o), 32'd1);
      expect_clear("A", c, 1'b1, c);
      next_cycle();
    end
    we_i = '0;
    #1;
    check("A ready c16", 32'(ready_o), 32'd1);
    for (int k = 0; k < DEPTH; k++)
      check($sformatf("A ram[%0d]", k), 32'(ram[k]), 32'(init_val(k)));

    // ---- B: READY-phase table ----------------------------------------------
    do_reset(4'b1111);
    repeat (16) next_cycle();
    #1;
    check("B ready c16", 32'(ready_o), 32'd1);
    for (int r = 0; r < 6; r++) begin
      partActive_i = vecs[r].act;
      we_i         = vecs[r].we;
      addrWr_i     = vecs[r].addr;
      dataWr_i     = vecs[r].data;
      #1;
      check($sformatf("B row%0d we_o", r), 32'(we_o), 32'(vecs[r].exp_we));
      check($sformatf("B row%0d addr", r), 32'(addrWr_o), 32'(vecs[r].addr));
      check($sformatf("B row%0d data", r), dataWr_o, vecs[r].data);
      check($sformatf("B row%0d ready", r), 32'(ready_o), 32'd1);
      check($sformatf("B row%0d errDrop", r), 32'(errDrop_o), 32'(vecs[r].exp_err));
      $display("[TB] B row %0d act=%b we=%b -> we_o=%b err=%b", r, vecs[r].act, vecs[r].we, we_o, errDrop_o);
      next_cycle();
    end

    // ---- C: partitions 0 and 2 active --------------------------------------
    do_reset(4'b0101);
    for (int c = 0; c < 10; c++) begin
      #1;
      if (c < 4)       expect_clear("C", c, 1'b1, c);
      else if (c == 4) expect_clear("C", c, 1'b0, 0);
      else if (c < 9)  expect_clear("C", c, 1'b1, c + 3);
      else             expect_clear("C", c, 1'b0, 0);
      next_cycle();
    end
    #1;
    check("C ready c10", 32'(ready_o), 32'd1);
    we_i = 4'b0001; addrWr_i = 16'h0005; dataWr_i = 32'h77;
    #1;
    check("C addr5 gated", 32'(we_o), 32'd0);
    check("C errDrop before", 32'(errDrop_o), 32'd0);
    next_cycle();
    addrWr_i = 16'h0009;
    #1;
    check("C errDrop after", 32'(errDrop_o), 32'd1);
    check("C addr9 passes", 32'(we_o), 32'd1);
    next_cycle();
    we_i = '0;

    // ---- D: partition 1 powers up while READY ------------------------------
    do_reset(4'b0001);
    for (int c = 0; c < 7; c++) begin
      #1;
      expect_clear("D", c, (c < 4), c);
      next_cycle();
    end
    // Detect cycle: still ready, but partition 1 is not clean yet.
    partActive_i = 4'b0011; we_i = 4'b0001; addrWr_i = 16'h0006; dataWr_i = 32'h55;
    #1;
    check("D detect ready", 32'(ready_o), 32'd1);
    check("D detect addr6 gated", 32'(we_o), 32'd0);
    next_cycle();
    we_i = '0;
    // Pointer left at 0 by the first scan, so partition 0 costs one skip.
    #1;
    expect_clear("D", 8, 1'b0, 0);
    next_cycle();
    for (int c = 0; c < 4; c++) begin
      #1;
      expect_clear("D", 9 + c, 1'b1, 4 + c);
      next_cycle();
    end
    we_i = 4'b0001; addrWr_i = 16'h0006;
    #1;
    check("D ready again", 32'(ready_o), 32'd1);
    check("D addr6 passes", 32'(we_o), 32'd1);
    next_cycle();
    we_i = '0;

    // ---- E: partition 0 powers up while ptr=10 -----------------------------
    do_reset(4'b1110);
    for (int c = 0; c < 17; c++) begin
      if (c == 7) partActive_i = 4'b1111;
      #1;
      if (c == 0)       expect_clear("E", c, 1'b0, 0);
      else if (c < 13)  expect_clear("E", c, 1'b1, c + 3);
      else              expect_clear("E", c, 1'b1, c - 13);
      next_cycle();
    end
    #1;
    check("E ready c17", 32'(ready_o), 32'd1);

    // ---- F: reset pulsed low while ptr=7 -----------------------------------
    do_reset(4'b1111);
    for (int c = 0; c < 8; c++) begin
      we_i = (c == 5) ? 4'b1111 : 4'b0000;
      #1;
      expect_clear("F", c, 1'b1, c);
      if (c == 7) check("F errDrop before reset", 32'(errDrop_o), 32'd1);
      if (c < 7) next_cycle();
    end
    reset = 1'b0;
    #1;
    check("F async errDrop", 32'(errDrop_o), 32'd0);
    check("F async addr0", 32'(addrWr_o[3:0]), 32'd0);
    next_cycle();
    reset = 1'b1;
    #1;
    expect_clear("F restart", 0, 1'b1, 0);
    check("F restart errDrop", 32'(errDrop_o), 32'd0);
    next_cycle();
    #1;
    expect_clear("F restart", 1, 1'b1, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
